// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: command encodings, divider FSM states
// and the conditional two's-complement helper used for sign handling.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;

  localparam logic [2:0] HILO_NOP  = 3'b000;
  localparam logic [2:0] HILO_MULT = 3'b001;
  localparam logic [2:0] HILO_DIV  = 3'b010;
  localparam logic [2:0] HILO_DIVU = 3'b011;
  localparam logic [2:0] HILO_MTHI = 3'b100;
  localparam logic [2:0] HILO_MTLO = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DIV  = 1'b1;

  function automatic logic [HILO_WIDTH-1:0] cond_neg(input logic neg,
                                                     input logic [HILO_WIDTH-1:0] x);
    return neg ? (~x + HILO_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/hilo_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, 32 steps per divide.
// Quotient/remainder are combinational and valid only in the done_o cycle.
module hilo_divider
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             step_ok;
  logic [WIDTH-1:0] next_rem, next_quo;

  // quo_q starts as the dividend and shifts out its MSB each step while the
  // new quotient bit enters at the LSB, so one register serves both roles.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, dsr_q};
    step_ok  = ~diff[WIDTH+1];
    next_rem = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    next_quo = {quo_q[WIDTH-2:0], step_ok};
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = '0;
          quo_d   = dividend_i;
          dsr_d   = divisor_i;
          cnt_d   = '0;
          state_d = ST_DIV;
        end
      end
      default: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = next_rem;
          quo_d = next_quo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign busy_o      = (state_q == ST_DIV);
  assign done_o      = (state_q == ST_DIV) && !abort_i && (cnt_q == LAST_STEP);
  assign quotient_o  = next_quo;
  assign remainder_o = next_rem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers: MULT capture, MTHI/MTLO writes and signed or
// unsigned 32-cycle division built around the unsigned restoring core.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             cmd_ready
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             quo_neg_q, rem_neg_q, div0_q;

  logic             accept, start, is_signed, rs_neg, rt_neg, div_done;
  logic [WIDTH-1:0] quotient, remainder;

  assign accept    = cmd_valid & ~busy;
  assign start     = accept & ((cmd == HILO_DIV) | (cmd == HILO_DIVU));
  assign is_signed = (cmd == HILO_DIV);
  assign rs_neg    = is_signed & rs[WIDTH-1];
  assign rt_neg    = is_signed & rt[WIDTH-1];
  assign cmd_ready = ~busy;

  hilo_divider #(.WIDTH(WIDTH)) u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .dividend_i (cond_neg(rs_neg, rs)),
    .divisor_i  (cond_neg(rt_neg, rt)),
    .busy_o     (busy),
    .done_o     (div_done),
    .quotient_o (quotient),
    .remainder_o(remainder)
  );

  // With a zero divisor the core leaves |rs| as remainder; restoring the
  // dividend sign yields rs itself, while the all-ones quotient stays raw.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      lo_d = cond_neg(quo_neg_q & ~div0_q, quotient);
      hi_d = cond_neg(rem_neg_q, remainder);
    end else if (accept) begin
      case (cmd)
        HILO_MULT: begin
          hi_d = alu_hi;
          lo_d = alu_lo;
        end
        HILO_MTHI: hi_d = rs;
        HILO_MTLO: lo_d = rs;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (start) begin
        quo_neg_q <= rs_neg ^ rt_neg;
        rem_neg_q <= rs_neg;
        div0_q    <= (rt == '0);
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus randomized command
// streams compared against an arithmetic reference model of HI/LO.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        abort;
  logic [31:0] alu_hi, alu_lo, rs, rt;
  logic [31:0] hi, lo;
  logic        busy, cmd_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .abort(abort),
    .alu_hi(alu_hi), .alu_lo(alu_lo), .rs(rs), .rt(rt),
    .hi(hi), .lo(lo), .busy(busy), .cmd_ready(cmd_ready)
  );

  // MIPS division semantics written directly from the architectural rules.
  function automatic void model_div(input bit sgn, input logic [31:0] a, b,
                                    output logic [31:0] q, r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called just after a falling edge; returns just after the next one.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, b, ah, al);
    cmd_valid = 1'b1; cmd = c; rs = a; rt = b; alu_hi = ah; alu_lo = al;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = HILO_NOP;
  endtask

  // Counts falling edges that see busy high; flags any HI/LO change meanwhile.
  task automatic wait_idle(output int cyc, output int unstable);
    cyc = 0;
    unstable = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (hi !== exp_hi || lo !== exp_lo) unstable++;
      @(negedge clk);
    end
  endtask

  task automatic check_hilo(input string name);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s: hi/lo got %h/%h expected %h/%h", name, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic do_div(input bit sgn, input logic [31:0] a, b, input string name);
    int cyc, unstable;
    logic [31:0] q, r;
    model_div(sgn, a, b, q, r);
    issue(sgn ? HILO_DIV : HILO_DIVU, a, b, 32'd0, 32'd0);
    wait_idle(cyc, unstable);
    checks++;
    if (cyc != 32) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected 32", name, cyc);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL %s hi/lo changed mid-divide on %0d cycles, expected 0", name, unstable);
    end
    exp_hi = r;
    exp_lo = q;
    check_hilo(name);
  endtask

  task automatic test_reset();
    int cyc, unstable;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = HILO_NOP; abort = 1'b0;
    alu_hi = '0; alu_lo = '0; rs = '0; rt = '0;
    #12;
    exp_hi = '0; exp_lo = '0;
    check_hilo("reset_state");
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state busy/ready got %b/%b expected 0/1", busy, cmd_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    issue(HILO_MULT, 0, 0, 32'hAAAA_0001, 32'h5555_0002);
    exp_hi = 32'hAAAA_0001; exp_lo = 32'h5555_0002;
    check_hilo("pre_reset_mult");
    issue(HILO_DIVU, 32'd1000, 32'd3, 0, 0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    check_hilo("reset_mid_divide");
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_divide busy/ready got %b/%b expected 0/1", busy, cmd_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    wait_idle(cyc, unstable);
    do_div(1'b0, 32'd1000, 32'd3, "divu_after_reset");
  endtask

  task automatic test_mult_mt();
    cmd_valid = 1'b1; cmd = HILO_MULT; alu_hi = 32'h1234_5678; alu_lo = 32'h9ABC_DEF0;
    #1 check_hilo("no_forwarding");
    @(negedge clk);
    cmd_valid = 1'b0; cmd = HILO_NOP;
    exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
    check_hilo("mult");
    issue(HILO_MTLO, 32'd5, 0, 0, 0);
    exp_lo = 32'd5;
    check_hilo("mtlo");
    issue(HILO_MTHI, 32'hCAFE_F00D, 0, 0, 0);
    exp_hi = 32'hCAFE_F00D;
    check_hilo("mthi");
    issue(3'b111, 32'h1111_1111, 0, 32'h2222_2222, 32'h3333_3333);
    check_hilo("nop_code");
  endtask

  task automatic test_divu_drop();
    int cyc, c2, unstable;
    cyc = 0;
    issue(HILO_DIVU, 32'd100, 32'd7, 0, 0);
    repeat (3) begin
      if (busy) cyc++;
      @(negedge clk);
    end
    cmd_valid = 1'b1; cmd = HILO_MULT; alu_hi = 32'hDEAD_BEEF; alu_lo = 32'hFEED_FACE;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_while_busy got %b expected 0", cmd_ready);
    end
    if (busy) cyc++;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = HILO_NOP;
    check_hilo("dropped_mult_now");
    wait_idle(c2, unstable);
    cyc += c2;
    checks++;
    if (cyc != 32) begin
      errors++;
      $display("FAIL divu_100_7 busy cycles: got %0d expected 32", cyc);
    end
    exp_hi = 32'd2; exp_lo = 32'd14;
    check_hilo("divu_100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_div(1'b0, 32'd9, 32'd0, "divu_by_zero");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd0, "div_neg_by_zero");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_max");
  endtask

  task automatic test_abort();
    int cyc, unstable;
    issue(HILO_MULT, 0, 0, 32'h0BAD_0001, 32'h0BAD_0002);
    exp_hi = 32'h0BAD_0001; exp_lo = 32'h0BAD_0002;
    issue(HILO_DIVU, 32'd50, 32'd3, 0, 0);
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_step20 busy/ready got %b/%b expected 0/1", busy, cmd_ready);
    end
    check_hilo("abort_step20");
    issue(HILO_DIVU, 32'd50, 32'd3, 0, 0);
    repeat (31) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_e32 got %b expected 1", busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_at_e32 busy got %b expected 0", busy);
    end
    check_hilo("abort_at_e32");
    abort = 1'b1;
    issue(HILO_DIVU, 32'd50, 32'd3, 0, 0);
    abort = 1'b0;
    wait_idle(cyc, unstable);
    checks++;
    if (cyc != 32) begin
      errors++;
      $display("FAIL abort_in_idle busy cycles: got %0d expected 32", cyc);
    end
    exp_hi = 32'd2; exp_lo = 32'd16;
    check_hilo("abort_in_idle");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int op;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 4);
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = $urandom_range(0, 255);
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
      case (op)
        0: begin
          issue(HILO_MULT, 0, 0, a, b);
          exp_hi = a; exp_lo = b;
          check_hilo("rand_mult");
        end
        1: begin
          issue(HILO_MTHI, a, b, 0, 0);
          exp_hi = a;
          check_hilo("rand_mthi");
        end
        2: begin
          issue(HILO_MTLO, a, b, 0, 0);
          exp_lo = a;
          check_hilo("rand_mtlo");
        end
        3: do_div(1'b1, a, b, "rand_div");
        default: do_div(1'b0, a, b, "rand_divu");
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_mult_mt();
    test_divu_drop();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
